// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: PC-source select codes,
// the nop word and the fetch FSM state type.
package fetch_unit_pkg;

    localparam logic [2:0] PCSRC_PLUS4 = 3'd0;
    localparam logic [2:0] PCSRC_BT    = 3'd1;
    localparam logic [2:0] PCSRC_JT    = 3'd2;
    localparam logic [2:0] PCSRC_JR    = 3'd3;

    localparam logic [31:0] INSTR_NOP = '0;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: req/addr from the fetch stage,
// ready/rdata back from memory.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC calculator: decides whether the instruction in IF/ID
// redirects fetch and computes the redirect target.
module fetch_npc
    import fetch_unit_pkg::*;
(
    input  logic        valid_i,
    input  logic [2:0]  sel_i,
    input  logic        taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] jidx_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] pc_plus4_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    always_comb begin
        redirect_o = 1'b0;
        target_o   = pc_plus4_i;
        case (sel_i)
            PCSRC_BT: begin
                redirect_o = valid_i & taken_i;
                target_o   = pc_plus4_i + {{14{imm16_i[15]}}, imm16_i, 2'b00};
            end
            PCSRC_JT: begin
                redirect_o = valid_i;
                target_o   = {pc_plus4_i[31:28], jidx_i, 2'b00};
            end
            PCSRC_JR: begin
                redirect_o = valid_i;
                target_o   = rs_val_i & ~32'h0000_0003;
            end
            default: begin
                redirect_o = 1'b0;
                target_o   = pc_plus4_i;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register; no delay slot, so an
// ID-stage redirect flushes the wrong-path fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       id_pc_src_sel,
    input  logic             id_branch_taken,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_jidx,
    input  logic [31:0]      id_rs_val,
    fetch_unit_if.master     imem,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;

    fetch_npc u_npc (
        .valid_i    (valid_q),
        .sel_i      (id_pc_src_sel),
        .taken_i    (id_branch_taken),
        .imm16_i    (id_imm16),
        .jidx_i     (id_jidx),
        .rs_val_i   (id_rs_val),
        .pc_plus4_i (pc4_q),
        .redirect_o (redirect),
        .target_o   (target)
    );

    assign pc_plus4       = pc_q + 32'd4;
    assign imem.imem_req  = rst & (state_q != S_HOLD);
    assign imem.imem_addr = pc_q;

    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            hold_instr_q <= '0;
            valid_q      <= 1'b0;
            instr_q      <= INSTR_NOP;
            pc4_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        hold_instr_d = hold_instr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;

        case (state_q)
            S_REQ: begin
                if (imem.imem_ready) begin
                    if (redirect) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        valid_d = 1'b1;
                        instr_d = imem.imem_rdata;
                        pc4_d   = pc_plus4;
                        pc_d    = pc_plus4;
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        state_d      = S_HOLD;
                    end
                end else if (redirect) begin
                    // Request must stay stable until ready, so park the target.
                    pend_pc_d = target;
                    valid_d   = 1'b0;
                    state_d   = S_DROP;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    instr_d = hold_instr_q;
                    pc4_d   = pc_plus4;
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem.imem_ready) begin
                    pc_d    = pend_pc_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, wait states, stall hold,
// branch/jump redirects, dropped response and reset out of S_HOLD.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  sel;
    logic        taken;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    fetch_unit_if bus ();

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.imem_ready = ready;
    assign bus.imem_rdata = memw(bus.imem_addr);

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_pc_src_sel   (sel),
        .id_branch_taken (taken),
        .id_imm16        (imm16),
        .id_jidx         (jidx),
        .id_rs_val       (rs_val),
        .imem            (bus),
        .if_id_valid     (valid),
        .if_id_instr     (instr),
        .if_id_pc_plus4  (pc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; sel = PCSRC_PLUS4; taken = 1'b0;
        imm16 = '0; jidx = '0; rs_val = '0; ready = 1'b1;

        step(); step();
        check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc4",   pc4, 32'd0);

        // Zero-wait sequential fetch
        rst = 1'b1; #1;
        check("t1_req",   {31'd0, bus.imem_req}, 32'd1);
        check("t1_addr0", bus.imem_addr, 32'h3000);
        step();
        check("t1_valid",  {31'd0, valid}, 32'd1);
        check("t1_instr0", instr, memw(32'h3000));
        check("t1_pc4_0",  pc4, 32'h3004);
        check("t1_addr1",  bus.imem_addr, 32'h3004);
        step();
        check("t1_instr1", instr, memw(32'h3004));
        check("t1_pc4_1",  pc4, 32'h3008);
        check("t1_addr2",  bus.imem_addr, 32'h3008);

        // Two wait states at 3008
        ready = 1'b0;
        step();
        check("t2_addr_w1",  bus.imem_addr, 32'h3008);
        check("t2_valid_w1", {31'd0, valid}, 32'd0);
        step();
        check("t2_addr_w2",  bus.imem_addr, 32'h3008);
        check("t2_valid_w2", {31'd0, valid}, 32'd0);
        ready = 1'b1; #1;
        check("t2_addr_w3",  bus.imem_addr, 32'h3008);
        step();
        check("t2_valid", {31'd0, valid}, 32'd1);
        check("t2_instr", instr, memw(32'h3008));
        check("t2_pc4",   pc4, 32'h300C);
        check("t2_addr",  bus.imem_addr, 32'h300C);
        ready = 1'b0;
        step();
        check("t2_once",  {31'd0, valid}, 32'd0);
        ready = 1'b1;
        step();
        check("t2_instr2", instr, memw(32'h300C));
        check("t2_pc4_2",  pc4, 32'h3010);
        check("t2_addr2",  bus.imem_addr, 32'h3010);

        // Stall while response arrives: word buffered, IF/ID frozen
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_req",   {31'd0, bus.imem_req}, 32'd0);
            check("t3_hold_valid", {31'd0, valid}, 32'd1);
            check("t3_hold_instr", instr, memw(32'h300C));
            check("t3_hold_pc4",   pc4, 32'h3010);
        end
        stall = 1'b0;
        step();
        check("t3_rel_valid", {31'd0, valid}, 32'd1);
        check("t3_rel_instr", instr, memw(32'h3010));
        check("t3_rel_pc4",   pc4, 32'h3014);
        check("t3_rel_addr",  bus.imem_addr, 32'h3014);

        // Branch not taken, then taken (pc4=3018, imm=-4 -> 3008)
        sel = PCSRC_BT; imm16 = 16'hFFFC; taken = 1'b0;
        step();
        check("t4_nt_addr",  bus.imem_addr, 32'h3018);
        check("t4_nt_pc4",   pc4, 32'h3018);
        check("t4_nt_valid", {31'd0, valid}, 32'd1);
        check("t4_nt_instr", instr, memw(32'h3014));
        taken = 1'b1;
        step();
        check("t4_tk_addr",  bus.imem_addr, 32'h3008);
        check("t4_tk_valid", {31'd0, valid}, 32'd0);
        sel = PCSRC_PLUS4; taken = 1'b0;
        step();
        check("t4_after_valid", {31'd0, valid}, 32'd1);
        check("t4_after_instr", instr, memw(32'h3008));
        check("t4_after_pc4",   pc4, 32'h300C);
        check("t4_after_addr",  bus.imem_addr, 32'h300C);

        // JR while memory not ready: response for 300C discarded
        sel = PCSRC_JR; rs_val = 32'h0000_4007; ready = 1'b0;
        step();
        check("t5_drop_req",   {31'd0, bus.imem_req}, 32'd1);
        check("t5_drop_addr",  bus.imem_addr, 32'h300C);
        check("t5_drop_valid", {31'd0, valid}, 32'd0);
        sel = PCSRC_PLUS4;
        step();
        check("t5_drop_addr2", bus.imem_addr, 32'h300C);
        stall = 1'b1; ready = 1'b1;
        step();
        check("t5_new_addr",  bus.imem_addr, 32'h4004);
        check("t5_new_valid", {31'd0, valid}, 32'd0);
        stall = 1'b0;
        step();
        check("t5_valid", {31'd0, valid}, 32'd1);
        check("t5_instr", instr, memw(32'h4004));
        check("t5_pc4",   pc4, 32'h4008);

        // Get pc4=F0000004 into IF/ID, then JAL
        sel = PCSRC_JR; rs_val = 32'hF000_0000;
        step();
        check("t6_jr_addr", bus.imem_addr, 32'hF000_0000);
        sel = PCSRC_PLUS4;
        step();
        check("t6_pc4", pc4, 32'hF000_0004);
        sel = PCSRC_JT; jidx = 26'h0000_400;
        step();
        check("t6_jal_addr",  bus.imem_addr, 32'hF000_1000);
        check("t6_jal_valid", {31'd0, valid}, 32'd0);
        sel = 3'd7;
        step();
        check("t6_u_valid", {31'd0, valid}, 32'd1);
        check("t6_u_instr", instr, memw(32'hF000_1000));
        step();
        check("t6_undef_addr", bus.imem_addr, 32'hF000_1008);
        check("t6_undef_pc4",  pc4, 32'hF000_1008);

        // Reset taken out of S_HOLD
        sel = PCSRC_PLUS4; stall = 1'b1;
        step();
        check("t7_hold_req", {31'd0, bus.imem_req}, 32'd0);
        rst = 1'b0; #1;
        check("t7_rst_req_comb", {31'd0, bus.imem_req}, 32'd0);
        step();
        check("t7_valid", {31'd0, valid}, 32'd0);
        check("t7_instr", instr, 32'd0);
        check("t7_req",   {31'd0, bus.imem_req}, 32'd0);
        stall = 1'b0; rst = 1'b1; #1;
        check("t7_addr", bus.imem_addr, 32'h3000);
        check("t7_req1", {31'd0, bus.imem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
